// File: rtl/timer_arbiter.sv
// timer_arbiter: N requesters time-share one WIDTH-bit up-counter and
// equality comparator, granted round-robin.
//
// Ports:
//   clk    - clock, all state updates on the rising edge
//   rst    - asynchronous active-high reset
//   req    - [N] level requests, held until the matching done is seen
//   load   - [N*WIDTH] per-requester delay, requester i at [i*WIDTH +: WIDTH]
//   grant  - [N] one-hot registered timer owner
//   done   - [N] one-hot registered one-cycle expiry pulse to the owner
//   busy   - high whenever the FSM is not IDLE
//   count  - [WIDTH] current counter value (debug)
//
// Optional build macro: TIMER_ARB_ABORT_EN
//   When defined, an owner that drops req during RUN aborts its grant
//   (back to IDLE, no done pulse). When undefined, req is ignored in RUN.

module timer_arbiter #(
  parameter int WIDTH = 8,
  parameter int N     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] load,
  output logic [N-1:0]       grant,
  output logic [N-1:0]       done,
  output logic               busy,
  output logic [WIDTH-1:0]   count
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [PW-1:0]    ptr, ptr_nx;
  logic [PW-1:0]    owner, owner_nx;
  logic [PW-1:0]    win;
  logic             found;
  logic [WIDTH-1:0] limit, limit_nx;
  logic [WIDTH-1:0] count_nx;
  logic [N-1:0]     grant_nx, done_nx;

  // Round-robin search: start just after the last owner, wrap mod N.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    owner_nx = owner;
    limit_nx = limit;
    count_nx = count;
    grant_nx = grant;
    done_nx  = '0;
    case (state)
      IDLE: begin
        count_nx = '0;
        if (found) begin
          // load is sampled only here; later changes do not affect expiry
          limit_nx      = load[int'(win)*WIDTH +: WIDTH];
          owner_nx      = win;
          grant_nx      = '0;
          grant_nx[win] = 1'b1;
          state_nx      = RUN;
        end
      end
      RUN: begin
`ifdef TIMER_ARB_ABORT_EN
        if (!req[owner]) begin
          state_nx = IDLE;
          grant_nx = '0;
          ptr_nx   = owner;
          count_nx = '0;
        end else
`endif
        if (count == limit) begin
          // count stops at limit, so limit = all-ones never wraps
          state_nx       = DONE;
          grant_nx       = '0;
          done_nx[owner] = 1'b1;
        end else begin
          count_nx = count + 1'b1;
        end
      end
      DONE: begin
        // ptr = owner puts a still-asserted owner behind everyone else
        ptr_nx   = owner;
        count_nx = '0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= PW'(N-1);
      owner <= '0;
      limit <= '0;
      count <= '0;
      grant <= '0;
      done  <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      owner <= owner_nx;
      limit <= limit_nx;
      count <= count_nx;
      grant <= grant_nx;
      done  <= done_nx;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed testbench for timer_arbiter. Stimulus pushes expected grant/done
// events and state snapshots into queues; a monitor pops and compares them.
module tb_timer_arbiter;
  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] load;
  logic [N-1:0]   grant, done;
  logic           busy;
  logic [W-1:0]   count;

  timer_arbiter #(.WIDTH(W), .N(N)) dut (
    .clk(clk), .rst(rst), .req(req), .load(load),
    .grant(grant), .done(done), .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_done;
    logic [N-1:0] vec;
    int         cyc;
    string      name;
  } ev_t;

  typedef struct {
    int         cyc;
    logic [N-1:0] g;
    logic [N-1:0] d;
    logic       b;
    logic [W-1:0] c;
    string      name;
  } snap_t;

  ev_t          ev_q[$];
  snap_t        snap_q[$];
  int           total = 0;
  int           bad   = 0;
  bit           stim_done = 1'b0;
  logic [N-1:0] persist = '0;

  task automatic expect_ev(input bit d, input int idx, input int c, input string n);
    ev_t e;
    e.is_done = d;
    e.vec = '0;
    e.vec[idx] = 1'b1;
    e.cyc = c;
    e.name = n;
    ev_q.push_back(e);
  endtask

  task automatic expect_snap(input int c, input logic [N-1:0] g, input logic [N-1:0] d,
                             input logic b, input logic [W-1:0] cn, input string n);
    snap_t s;
    s.cyc = c; s.g = g; s.d = d; s.b = b; s.c = cn; s.name = n;
    snap_q.push_back(s);
  endtask

  task automatic set_load(input int i, input logic [W-1:0] v);
    load[i*W +: W] = v;
  endtask

  // One clock: requesters not marked persistent drop req when they see done.
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < N; i++)
      if (done[i] && !persist[i]) req[i] = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick();
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d (cyc=%0d)", n, act, exp, cyc);
    end
  endtask

  task automatic pop_ev(input bit is_done, input logic [N-1:0] vec);
    ev_t e;
    if (ev_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_%s got=%b want=none (cyc=%0d)",
               is_done ? "done" : "grant", vec, cyc);
    end else begin
      e = ev_q.pop_front();
      chk({e.name, ".kind"}, int'(is_done), int'(e.is_done));
      chk({e.name, ".vec"}, int'(vec), int'(e.vec));
      chk({e.name, ".cyc"}, cyc, e.cyc);
    end
  endtask

  initial begin : monitor
    logic [N-1:0] pg;
    snap_t s;
    pg = '0;
    forever begin
      @(negedge clk);
      if (grant != '0 && pg == '0) pop_ev(1'b0, grant);
      if (done != '0) pop_ev(1'b1, done);
      pg = grant;
      while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
        s = snap_q.pop_front();
        chk({s.name, ".cyc"}, cyc, s.cyc);
        chk({s.name, ".grant"}, int'(grant), int'(s.g));
        chk({s.name, ".done"}, int'(done), int'(s.d));
        chk({s.name, ".busy"}, int'(busy), int'(s.b));
        chk({s.name, ".count"}, int'(count), int'(s.c));
      end
      if (stim_done || cyc > 20000) begin
        if (!stim_done) begin
          total++;
          bad++;
          $display("FAIL timeout got=cyc%0d want=stimulus_end", cyc);
        end
        chk("ev_q_drained", ev_q.size(), 0);
        chk("snap_q_drained", snap_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int k;
    rst  = 1'b1;
    req  = '0;
    load = '0;
    expect_snap(1, 4'b0000, 4'b0000, 1'b0, 8'd0, "reset");
    @(posedge clk); #1;
    tick();
    rst = 1'b0;
    tick();

    // single request, load 5
    k = cyc;
    req[0] = 1'b1; set_load(0, 8'd5);
    expect_ev(0, 0, k + 1, "t1_grant");
    expect_ev(1, 0, k + 7, "t1_done");
    for (int j = 0; j <= 5; j++)
      expect_snap(k + 1 + j, 4'b0001, 4'b0000, 1'b1, W'(j), "t1_run");
    expect_snap(k + 7, 4'b0000, 4'b0001, 1'b1, 8'd5, "t1_donest");
    expect_snap(k + 8, 4'b0000, 4'b0000, 1'b0, 8'd0, "t1_idle");
    wait_cyc(k + 8);

    // reset mid-RUN at count 3 of load 10
    k = cyc;
    req[1] = 1'b1; set_load(1, 8'd10);
    expect_ev(0, 1, k + 1, "t2_grant");
    expect_snap(k + 3, 4'b0010, 4'b0000, 1'b1, 8'd2, "t2_pre");
    wait_cyc(k + 4);
    rst = 1'b1;
    req = '0;
    expect_snap(k + 4, 4'b0000, 4'b0000, 1'b0, 8'd0, "t2_rst");
    tick();
    rst = 1'b0;

    // all-request fairness after reset: order 0,1,2,3, period 5
    k = cyc;
    req = 4'b1111;
    for (int i = 0; i < N; i++) set_load(i, 8'd2);
    for (int i = 0; i < N; i++) begin
      expect_ev(0, i, k + 1 + 5 * i, "t3_grant");
      expect_ev(1, i, k + 4 + 5 * i, "t3_done");
    end
    expect_snap(k + 20, 4'b0000, 4'b0000, 1'b0, 8'd0, "t3_idle");
    wait_cyc(k + 20);

    // persistent requesters 0 and 2 alternate
    k = cyc;
    persist = 4'b0101;
    req = 4'b0101;
    set_load(0, 8'd1); set_load(2, 8'd1);
    expect_ev(0, 0, k + 1,  "t4_g0a"); expect_ev(1, 0, k + 3,  "t4_d0a");
    expect_ev(0, 2, k + 5,  "t4_g2a"); expect_ev(1, 2, k + 7,  "t4_d2a");
    expect_ev(0, 0, k + 9,  "t4_g0b"); expect_ev(1, 0, k + 11, "t4_d0b");
    expect_ev(0, 2, k + 13, "t4_g2b"); expect_ev(1, 2, k + 15, "t4_d2b");
    expect_snap(k + 16, 4'b0000, 4'b0000, 1'b0, 8'd0, "t4_idle");
    wait_cyc(k + 15);
    req = '0;
    persist = '0;
    wait_cyc(k + 16);

    // load 0: done one cycle after grant (ptr=2 -> requester 1 wins)
    k = cyc;
    req[1] = 1'b1; set_load(1, 8'd0);
    expect_ev(0, 1, k + 1, "t5_grant");
    expect_ev(1, 1, k + 2, "t5_done");
    expect_snap(k + 1, 4'b0010, 4'b0000, 1'b1, 8'd0, "t5_run");
    wait_cyc(k + 3);

    // load 255: full range, count holds 255 in DONE
    k = cyc;
    req[3] = 1'b1; set_load(3, 8'd255);
    expect_ev(0, 3, k + 1, "t6_grant");
    expect_ev(1, 3, k + 257, "t6_done");
    expect_snap(k + 256, 4'b1000, 4'b0000, 1'b1, 8'd255, "t6_top");
    expect_snap(k + 257, 4'b0000, 4'b1000, 1'b1, 8'd255, "t6_nowrap");
    wait_cyc(k + 258);

    // load changed mid-RUN has no effect
    k = cyc;
    req[2] = 1'b1; set_load(2, 8'd4);
    expect_ev(0, 2, k + 1, "t7_grant");
    expect_ev(1, 2, k + 6, "t7_done");
    wait_cyc(k + 2);
    set_load(2, 8'd1);
    wait_cyc(k + 7);

    // owner drops req at count 2 of load 8
    k = cyc;
    req[0] = 1'b1; set_load(0, 8'd8);
    expect_ev(0, 0, k + 1, "t8_grant");
    expect_snap(k + 3, 4'b0001, 4'b0000, 1'b1, 8'd2, "t8_pre");
`ifdef TIMER_ARB_ABORT_EN
    expect_snap(k + 4, 4'b0000, 4'b0000, 1'b0, 8'd0, "t8_abort");
`else
    expect_ev(1, 0, k + 10, "t8_done");
    expect_snap(k + 4, 4'b0001, 4'b0000, 1'b1, 8'd3, "t8_noabort");
`endif
    wait_cyc(k + 3);
    req[0] = 1'b0;
    wait_cyc(k + 12);

    stim_done = 1'b1;
  end
endmodule

// File: doc/timer_arbiter.md
# timer_arbiter

Shared-timer scheduler for the counter/comparator tick datapath. It lets N requesters time-share one WIDTH-bit up-counter and equality comparator. The requesters are granted round-robin, and each gets its own delay value. The granted requester receives a one-cycle registered `done` pulse when its delay expires. This block sits between the control logic that needs delays and the single timer resource, replacing per-client timer instances.

## Interface
- `WIDTH`, default 8: counter, comparator and load-value width.
- `N`, default 4: number of requesters (N ≥ 2).

- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in N: level request per requester; held high until its `done` is seen.
- `load` in N*WIDTH: delay per requester; requester i uses bits [i*WIDTH +: WIDTH].
- `grant` out N: one-hot, registered; identifies the current timer owner.
- `done` out N: one-hot, registered, one-cycle pulse to the finished owner.
- `busy` out 1: high whenever the state is not IDLE.
- `count` out WIDTH: current counter value, for debug and visibility.

## Operation
- FSM states: IDLE, RUN, DONE. Reset enters IDLE.
- Reset values:
  - `grant`=0, `done`=0, `busy`=0, `count`=0.
  - Internal `limit`=0, `owner`=0, round-robin pointer `ptr`=N-1, so the first search starts at requester 0.
- IDLE, when any `req` bit is high:
  - Search i = ptr+1 … ptr+N (mod N); the first high `req[i]` wins.
  - `limit` ← `load[i]`, `count` ← 0, `owner` ← i, `grant` ← one-hot(i), go to RUN.
- IDLE, with no request: hold; `count` stays 0.
- RUN:
  - If `count` == `limit`: go to DONE, `grant` ← 0, `done[owner]` ← 1.
  - Otherwise: `count` ← `count`+1.
- DONE (one cycle): `done` ← 0, `ptr` ← `owner`, `count` ← 0, go to IDLE.
- Load sampling and width rules:
  - `load` is sampled only at grant; changes to `load` during RUN are ignored.
  - `count` never exceeds `limit`, so no wrap occurs. `limit` = 2^WIDTH-1 is legal and counts the full range.
  - `limit` = 0 gives one RUN cycle.
- Request handshake:
  - A requester must drop `req` on the edge where it samples `done` high.
  - A `req` still high in the following IDLE cycle is treated as a new request and arbitrated normally; it goes behind the others because `ptr` = `owner`.
- Simultaneous requests are resolved only by the round-robin order.
- New requests arriving during RUN or DONE wait for IDLE.
- Asynchronous `rst` at any point, including mid-RUN:
  - Forces IDLE and all reset values immediately.
  - No `done` pulse is issued for the interrupted grant.

## Timing
- Request to grant: `req` high in an IDLE cycle → `grant` high from the next cycle.
- Grant to done: `grant` rise → `done` rise exactly `limit`+1 cycles later.
  - `grant` falls on the same edge that `done` rises.
- `busy` (registered) is high for `limit`+2 cycles per grant: RUN for `limit`+1 cycles, DONE for 1 cycle.
- Back-to-back grants: the minimum idle gap between grants is one IDLE cycle. Per-grant period is `limit`+3 cycles.

## Configuration
- `TIMER_ARB_ABORT_EN` defined:
  - If `req[owner]` is low in any RUN cycle, the next state is IDLE with `grant` ← 0, `ptr` ← `owner`, `count` ← 0.
  - No `done` pulse is issued.
- `TIMER_ARB_ABORT_EN` undefined: `req` is ignored during RUN; the timing always completes and pulses `done`.

## Test plan
- Single request, `rst` low:
  - Stimulus: `req`=0001, `load[0]`=5 at cycle 0.
  - Response: `grant`=0001 from cycle 1; `done`=0001 for exactly cycle 7; `busy` high cycles 1–7; `count` runs 0..5.
- All-request fairness:
  - Stimulus: `req`=1111, every `load`=2; each requester drops `req` on its `done`.
  - Response: grants in order 0,1,2,3; each `done` 3 cycles after its grant; 5-cycle grant period.
- Persistent requesters:
  - Stimulus: `req[0]` and `req[2]` re-asserted immediately after each `done`.
  - Response: grants alternate 0,2,0,2; requester 0 is never granted twice in a row.
- Boundary loads:
  - `load`=0 → `done` 1 cycle after `grant`.
  - `load`=255 (WIDTH=8) → `done` 256 cycles after `grant`, with no wrap of `count`.
  - `load` changed mid-RUN → no effect on expiry.
- Reset mid-RUN:
  - Stimulus: assert `rst` at `count`=3 of `load`=10.
  - Response: `grant`, `done`, `busy`, `count` all 0 immediately. After release, the first grant goes to requester 0 if requested.
- Abort, with and without the macro:
  - Stimulus: drop `req[owner]` at `count`=2 of `load`=8.
  - With `TIMER_ARB_ABORT_EN`: IDLE next cycle, no `done`.
  - Without it: `done` still fires 9 cycles after `grant`.
